// File: rtl/scan_ctrl_pkg.sv
// rtl/scan_ctrl_pkg.sv - shared types and sizing helpers for the scan chain sequencer
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        REPORT
    } scan_state_e;

    localparam int REPORT_LEN = 1;

    // One counter serves every phase, so it must hold the longest phase length.
    function automatic int cnt_width(input int chain_len, input int capture_cyc);
        int longest;
        longest = (chain_len > capture_cyc) ? chain_len : capture_cyc;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/scan_shreg.sv
// rtl/scan_shreg.sv - parallel-load shift register, MSB-first out, serial-in at LSB
module scan_shreg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q,
    output logic         sout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[W-2:0], sin};
        end
    end

    assign sout = q[W-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - scan load/capture/unload sequencer; SCAN_CTRL_MASK_EN adds MASK_IN compare masking
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN   = 16,
    parameter int CAPTURE_CYC = 1
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic [CHAIN_LEN-1:0] EXP_IN,
`ifdef SCAN_CTRL_MASK_EN
    input  logic [CHAIN_LEN-1:0] MASK_IN,
`endif
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 FAIL,
    output logic [CHAIN_LEN-1:0] RESULT
);

    localparam int CW = cnt_width(CHAIN_LEN, CAPTURE_CYC);

    scan_state_e          state;
    logic [CW-1:0]        cnt;
    logic [CHAIN_LEN-1:0] exp_q;
    logic                 accept;
    logic                 cnt_zero;
    logic                 mismatch;
    logic [CHAIN_LEN-1:0] unload_word;
    logic [CHAIN_LEN-1:0] unused_piso_q;
    logic                 unused_sipo_sout;

    assign accept   = (state == IDLE) && START;
    assign cnt_zero = (cnt == '0);

    // The last unload edge is also the edge that registers FAIL, so compare
    // against the word including the bit arriving on SO right now.
    assign unload_word = {RESULT[CHAIN_LEN-2:0], SO};

`ifdef SCAN_CTRL_MASK_EN
    logic [CHAIN_LEN-1:0] mask_q;
    assign mismatch = |((unload_word ^ exp_q) & ~mask_q);
`else
    assign mismatch = (unload_word != exp_q);
`endif

    scan_shreg #(.W(CHAIN_LEN)) u_piso (
        .clk       (CK),
        .rst       (RST),
        .load      (accept),
        .load_data (PAT_IN),
        .shift     (state == LOAD),
        .sin       (1'b0),
        .q         (unused_piso_q),
        .sout      (SI)
    );

    scan_shreg #(.W(CHAIN_LEN)) u_sipo (
        .clk       (CK),
        .rst       (RST),
        .load      (accept),
        .load_data ('0),
        .shift     (state == UNLOAD),
        .sin       (SO),
        .q         (RESULT),
        .sout      (unused_sipo_sout)
    );

    always_ff @(posedge CK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            SE    <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            FAIL  <= 1'b0;
            exp_q <= '0;
`ifdef SCAN_CTRL_MASK_EN
            mask_q <= '0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state <= LOAD;
                        cnt   <= CW'(CHAIN_LEN - 1);
                        SE    <= 1'b1;
                        BUSY  <= 1'b1;
                        FAIL  <= 1'b0;
                        exp_q <= EXP_IN;
`ifdef SCAN_CTRL_MASK_EN
                        mask_q <= MASK_IN;
`endif
                    end
                end
                LOAD: begin
                    if (cnt_zero) begin
                        state <= CAPTURE;
                        cnt   <= CW'(CAPTURE_CYC - 1);
                        SE    <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (cnt_zero) begin
                        state <= UNLOAD;
                        cnt   <= CW'(CHAIN_LEN - 1);
                        SE    <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                UNLOAD: begin
                    if (cnt_zero) begin
                        state <= REPORT;
                        cnt   <= CW'(REPORT_LEN - 1);
                        SE    <= 1'b0;
                        DONE  <= 1'b1;
                        FAIL  <= mismatch;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                REPORT: begin
                    if (cnt_zero) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        cnt  <= cnt - 1'b1;
                        DONE <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - scoreboard bench for scan_chain_ctrl (N=4/C=1 inverting chain, N=16/C=3 shift chain)
module tb_scan_chain_ctrl;

    localparam int NA = 4;
    localparam int CA = 1;
    localparam int NB = 16;
    localparam int CB = 3;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic RST;
    logic start_a, start_b;
    logic [NA-1:0] pat_a, exp_a, mask_a, result_a;
    logic [NB-1:0] pat_b, exp_b, mask_b, result_b;
    logic so_a, se_a, si_a, busy_a, done_a, fail_a;
    logic so_b, se_b, si_b, busy_b, done_b, fail_b;

    logic [NA-1:0] chain_a = '0;
    logic [NB-1:0] chain_b = '0;

    // Chain A: capture loads ~Q; chain B: capture holds.
    always @(posedge CK) chain_a <= se_a ? {chain_a[NA-2:0], si_a} : ~chain_a;
    always @(posedge CK) chain_b <= se_b ? {chain_b[NB-2:0], si_b} : chain_b;
    assign so_a = chain_a[NA-1];
    assign so_b = chain_b[NB-1];

    scan_chain_ctrl #(.CHAIN_LEN(NA), .CAPTURE_CYC(CA)) dut_a (
        .CK(CK), .RST(RST), .START(start_a), .PAT_IN(pat_a), .EXP_IN(exp_a),
`ifdef SCAN_CTRL_MASK_EN
        .MASK_IN(mask_a),
`endif
        .SO(so_a), .SE(se_a), .SI(si_a), .BUSY(busy_a), .DONE(done_a),
        .FAIL(fail_a), .RESULT(result_a)
    );

    scan_chain_ctrl #(.CHAIN_LEN(NB), .CAPTURE_CYC(CB)) dut_b (
        .CK(CK), .RST(RST), .START(start_b), .PAT_IN(pat_b), .EXP_IN(exp_b),
`ifdef SCAN_CTRL_MASK_EN
        .MASK_IN(mask_b),
`endif
        .SO(so_b), .SE(se_b), .SI(si_b), .BUSY(busy_b), .DONE(done_b),
        .FAIL(fail_b), .RESULT(result_b)
    );

    int nchecks = 0;
    int nerrs   = 0;
    int dones_a = 0;
    int dones_b = 0;
    logic [NA:0] q_a[$];
    logic [NB:0] q_b[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        nchecks++;
        if (got !== want) begin
            nerrs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    always @(negedge CK) begin
        logic [NA:0] ea;
        logic [NB:0] eb;
        if (done_a) begin
            dones_a++;
            check("a_sb_nonempty", q_a.size() != 0, 1);
            if (q_a.size() != 0) begin
                ea = q_a.pop_front();
                check("a_result", result_a, ea[NA-1:0]);
                check("a_fail", fail_a, ea[NA]);
            end
        end
        if (done_b) begin
            dones_b++;
            check("b_sb_nonempty", q_b.size() != 0, 1);
            if (q_b.size() != 0) begin
                eb = q_b.pop_front();
                check("b_result", result_b, eb[NB-1:0]);
                check("b_fail", fail_b, eb[NB]);
            end
        end
    end

    // One pass on DUT A starting in the current cycle (cycle 0); returns in cycle 11.
    task automatic pass_a(input logic [NA-1:0] pat, input logic [NA-1:0] expw,
                          input logic [NA-1:0] mask, input int ign1, input int ign2,
                          input int rst_cyc);
        logic [NA-1:0] r;
        logic f;
        int d0;
        r = pat;
        for (int i = 0; i < CA; i++) r = ~r;
`ifdef SCAN_CTRL_MASK_EN
        f = |((r ^ expw) & ~mask);
`else
        f = (r != expw);
`endif
        pat_a = pat; exp_a = expw; mask_a = mask; start_a = 1'b1;
        q_a.push_back({f, r});
        d0 = dones_a;
        tick();
        start_a = 1'b0;
        for (int c = 1; c <= 2*NA+CA+2; c++) begin
            if (c == 1) begin
                check("a_fail_cleared", fail_a, 0);
                check("a_result_cleared", result_a, 0);
            end
            check("a_busy", busy_a, c <= 2*NA+CA+1);
            check("a_se", se_a, (c <= NA) || (c >= NA+CA+1 && c <= 2*NA+CA));
            if (c <= NA) check("a_si", si_a, pat[NA-c]);
            else check("a_si_idle", si_a, 0);
            check("a_done", done_a, c == 2*NA+CA+1);
            if (c == rst_cyc) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
                check("a_rst_se", se_a, 0);
                check("a_rst_si", si_a, 0);
                check("a_rst_busy", busy_a, 0);
                check("a_rst_done", done_a, 0);
                check("a_rst_fail", fail_a, 0);
                check("a_rst_result", result_a, 0);
                q_a.delete();
                return;
            end
            if (c == 2*NA+CA+2) begin
                check("a_fail_held", fail_a, f);
                check("a_result_held", result_a, r);
                check("a_one_done", dones_a - d0, 1);
            end else begin
                start_a = (c == ign1) || (c == ign2);
                if (start_a) pat_a = 4'($urandom);
                tick();
                start_a = 1'b0;
            end
        end
    endtask

    initial begin
        int d0;
        RST = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        pat_a = '0; exp_a = '0; mask_a = '0;
        pat_b = '0; exp_b = '0; mask_b = '0;
        repeat (3) tick();
        check("rst_se", se_a, 0);
        check("rst_si", si_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_fail", fail_a, 0);
        check("rst_result", result_a, 0);
        check("rst_b_busy", busy_b, 0);
        check("rst_b_result", result_b, 0);
        RST = 1'b0;
        tick();

        pass_a(4'b1011, 4'b0100, 4'b0000, 0, 0, 0);
        pass_a(4'b1011, 4'b0101, 4'b0000, 0, 0, 0);
        repeat (3) begin
            tick();
            check("a_fail_idle_hold", fail_a, 1);
            check("a_result_idle_hold", result_a, 4'b0100);
        end
        pass_a(4'b1011, 4'b0100, 4'b0000, 3, 10, 0);
        pass_a(4'b0110, 4'b1001, 4'b0000, 0, 0, 0);
        pass_a(4'b1011, 4'b0100, 4'b0000, 0, 0, 6);
        pass_a(4'b0011, 4'b1100, 4'b0000, 0, 0, 0);
`ifdef SCAN_CTRL_MASK_EN
        pass_a(4'b1011, 4'b0000, 4'b0100, 0, 0, 0);
        pass_a(4'b1011, 4'b0000, 4'b0000, 0, 0, 0);
`endif

        pat_b = 16'hA5C3; exp_b = 16'hA5C3; start_b = 1'b1;
        q_b.push_back({1'b0, 16'hA5C3});
        d0 = dones_b;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 2*NB+CB+2; c++) begin
            check("b_done", done_b, c == 2*NB+CB+1);
            check("b_busy", busy_b, c <= 2*NB+CB+1);
            tick();
        end
        check("b_one_done", dones_b - d0, 1);
        check("b_result_held", result_b, 16'hA5C3);

        check("a_sb_drained", q_a.size(), 0);
        check("b_sb_drained", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end

endmodule
